// File: rtl/div_sched.sv
// Iterative radix-2 restoring divide sequencer for the EX stage (DW+1 cycles per divide).
// Optional macro DIV_SIGNED_EN enables signed DIV; without it every request is DIVU.
module div_sched #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            annul_i,
    input  logic            signed_div_i,
    input  logic [DW-1:0]   opdata1_i,
    input  logic [DW-1:0]   opdata2_i,
    output logic [2*DW-1:0] result_o,
    output logic            ready_o,
    output logic            stallreq_o
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [2*DW:0]     acc_reg, acc_next;
    logic [DW-1:0]     divisor_reg, divisor_next;
    logic [2*DW-1:0]   result_reg, result_next;
    logic              ready_reg, ready_next;

    logic [DW-1:0]     mag1, mag2;
    logic [DW-1:0]     quo_fix, rem_fix;
    logic              accept;

    assign accept = (state_reg == IDLE) && start_i && !annul_i;

`ifdef DIV_SIGNED_EN
    logic sign1, sign2;
    logic sign_q_reg, sign_q_next, sign_r_reg, sign_r_next;

    assign sign1 = signed_div_i & opdata1_i[DW-1];
    assign sign2 = signed_div_i & opdata2_i[DW-1];
    assign mag1  = sign1 ? -opdata1_i : opdata1_i;
    assign mag2  = sign2 ? -opdata2_i : opdata2_i;

    // Quotient takes the XOR of operand signs, remainder follows the dividend.
    assign quo_fix = sign_q_reg ? -acc_reg[DW-1:0]      : acc_reg[DW-1:0];
    assign rem_fix = sign_r_reg ? -acc_reg[2*DW-1:DW]   : acc_reg[2*DW-1:DW];

    always_comb begin
        sign_q_next = sign_q_reg;
        sign_r_next = sign_r_reg;
        if (accept) begin
            sign_q_next = sign1 ^ sign2;
            sign_r_next = sign1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
        end else begin
            sign_q_reg <= sign_q_next;
            sign_r_reg <= sign_r_next;
        end
    end
`else
    logic signed_unused;

    assign signed_unused = signed_div_i;
    assign mag1    = opdata1_i;
    assign mag2    = opdata2_i;
    assign quo_fix = acc_reg[DW-1:0];
    assign rem_fix = acc_reg[2*DW-1:DW];
`endif

    logic [2*DW:0]  acc_sh;
    logic [DW+1:0]  trial;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        acc_next     = acc_reg;
        divisor_next = divisor_reg;
        result_next  = result_reg;
        ready_next   = ready_reg;
        acc_sh       = acc_reg << 1;
        // Extra top bit of the trial difference is the borrow (negative result).
        trial        = {1'b0, acc_sh[2*DW:DW]} - {2'b00, divisor_reg};

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    divisor_next = mag2;
                    if (opdata2_i == '0) begin
                        state_next = DIVZERO;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = '0;
                        acc_next   = {{(DW+1){1'b0}}, mag1};
                    end
                end
            end
            BUSY: begin
                if (annul_i) begin
                    state_next = IDLE;
                end else if (cnt_reg < CW'(DW)) begin
                    cnt_next = cnt_reg + CW'(1);
                    if (!trial[DW+1]) begin
                        acc_next    = {trial[DW:0], acc_sh[DW-1:0]};
                        acc_next[0] = 1'b1;
                    end else begin
                        acc_next = acc_sh;
                    end
                end else begin
                    result_next = {rem_fix, quo_fix};
                    ready_next  = 1'b1;
                    state_next  = DONE;
                end
            end
            DIVZERO: begin
                if (annul_i) begin
                    state_next = IDLE;
                end else begin
                    result_next = '0;
                    ready_next  = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (!start_i || annul_i) begin
                    state_next  = IDLE;
                    ready_next  = 1'b0;
                    result_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            divisor_reg <= '0;
            result_reg  <= '0;
            ready_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            acc_reg     <= acc_next;
            divisor_reg <= divisor_next;
            result_reg  <= result_next;
            ready_reg   <= ready_next;
        end
    end

    assign result_o   = result_reg;
    assign ready_o    = ready_reg;
    assign stallreq_o = start_i & ~ready_reg & ~annul_i;

endmodule

// File: doc/div_sched.md
# div_sched

Iterative divide sequencer for the EX stage. It accepts a DIV/DIVU request from EX and runs a radix-2 restoring division over DW+1 cycles. While it runs, it raises a pipeline stall request. When done, it presents the {remainder, quotient} pair that EX forwards toward HILO (hi = remainder, lo = quotient). It sits beside `ex0` and is the only multi-cycle resource in the pipeline.

## Interface
Parameters:
- DW, 32, operand width; the iteration count equals DW.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-low
- start_i  in  1  divide request from EX; held high until ready_o is seen
- annul_i  in  1  cancel request (flush); overrides start_i
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  DW  dividend; sampled only when a request is accepted
- opdata2_i  in  DW  divisor; sampled only when a request is accepted
- result_o  out  2*DW  {remainder[2DW-1:DW], quotient[DW-1:0]}
- ready_o  out  1  result_o valid
- stallreq_o  out  1  stall request to the pipeline controller

## Operation
- State machine has four states: IDLE, DIVZERO, BUSY, DONE.
- Internal registers: a 2*DW+1 shift register `acc`, a divisor register, a counter `cnt` (0..DW), and latched sign flags.

IDLE
- If start_i=1 and annul_i=0, the request is accepted:
  - Divisor = 0 -> go to DIVZERO.
  - Otherwise -> go to BUSY, with cnt=0 and acc={DW'b0, |dividend|}.
- For a signed request, the magnitudes of both operands (two's complement abs) are loaded. The sign of the quotient (s1^s2) and the sign of the remainder (s1) are latched.

BUSY
- If annul_i=1 -> go to IDLE; the partial result is discarded.
- Else if cnt<DW, one iteration runs:
  - Shift acc left by 1.
  - Trial-subtract the divisor from the upper DW+1 bits.
  - If non-negative: keep the difference and set acc[0]=1.
  - cnt increments.
- Else (cnt==DW), the result is finalized:
  - Quotient and remainder are negated per the latched signs.
  - result_o is loaded, ready_o is set to 1, and the state moves to DONE.

DIVZERO
- Next edge: result_o = 0, ready_o = 1, go to DONE.
- Division by zero is architecturally undefined; 0 is the chosen value.

DONE
- ready_o and result_o hold while start_i=1.
- If start_i=0 or annul_i=1 -> go to IDLE, with ready_o=0 and result_o cleared to 0.

Rules and corner cases
- stallreq_o = start_i & ~ready_o & ~annul_i (combinational). EX stays stalled until the result cycle.
- Arithmetic is modulo 2^DW. For signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0, with no trap.
- Operand changes after acceptance have no effect.
- A new request is accepted only in IDLE. Back-to-back divides therefore need start_i low for at least one cycle, or a pass through DONE->IDLE.

## Timing
- Reset (rst=0 at an edge): state=IDLE, cnt=0, acc=0, result_o=0, ready_o=0. stallreq_o then follows start_i.
- Reset mid-operation aborts immediately and no result is produced.
- Latency, with the accept edge counted as E0:
  - Non-zero divisor: ready_o rises after edge E(DW+1), i.e. 33 cycles for DW=32.
  - Zero divisor: ready_o rises after edge E1.
- ready_o lasts at least 1 cycle and drops on the edge after start_i falls.
- annul_i and start_i high together: annul wins in every state.

## Configuration
- DIV_SIGNED_EN defined:
  - signed_div_i is honoured.
  - Magnitude conversion and sign fix-up logic are present.
- DIV_SIGNED_EN undefined:
  - signed_div_i is ignored and every request is treated as DIVU.
  - Sign flags are tied to 0 and the abs/negate logic is removed.
  - Signed test cases must be skipped.

## Test plan
- DIVU 100 / 7 -> ready_o high 33 cycles after accept, result_o = {0x00000002, 0x0000000E}; stallreq_o high through cycles 0..32, low once ready_o is high.
- DIV (signed) -7 / 2, i.e. 0xFFFFFFF9 / 0x00000002 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Also 7 / -2 -> {0x00000001, 0xFFFFFFFD}.
- Divide by zero, 0x1234 / 0 -> ready_o high after 2 edges, result_o = 0. Also 0x80000000 / 0xFFFFFFFF signed -> {0x00000000, 0x80000000}.
- annul_i pulsed at cycle 10 of BUSY -> IDLE next edge. ready_o never rises. A fresh 9 / 3 request then returns {0, 3} in 33 cycles.
- rst=0 for one cycle mid-BUSY -> all outputs 0 next edge. A following 0xFFFFFFFF / 1 (DIVU) -> {0, 0xFFFFFFFF}.
- Back-to-back: hold start_i through DONE with new operands, then drop for 1 cycle and re-raise -> the second result uses only the second operand pair. The first result_o holds until start_i falls.
